// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift unit: mode encoding and mode decode helpers.
package shift_pkg;

  typedef enum logic [2:0] {
    ModeSll = 3'b000,
    ModeSrl = 3'b001,
    ModeSra = 3'b010,
    ModeSla = 3'b011,
    ModeRol = 3'b100,
    ModeRor = 3'b101
  } shift_mode_e;

  // Encodings 110 and 111 have no operation behind them.
  function automatic logic mode_illegal(input logic [2:0] mode);
    return mode[2] & mode[1];
  endfunction

  function automatic logic mode_rotate(input logic [2:0] mode);
    return (mode == ModeRol) || (mode == ModeRor);
  endfunction

  function automatic logic mode_left(input logic [2:0] mode);
    return (mode == ModeSll) || (mode == ModeSla) || (mode == ModeRol);
  endfunction

endpackage

// File: rtl/shift_layer.sv
// One barrel-shifter layer: moves the operand by 2**K when enabled and keeps the running
// carry-out and SLA overflow up to date.
module shift_layer
  import shift_pkg::*;
#(
  parameter int unsigned BITS = 8,
  parameter int unsigned K    = 0
) (
  input  logic            en,
  input  logic [BITS-1:0] data,
  input  logic [2:0]      mode,
  input  logic            sign,
  input  logic            carry,
  input  logic            over,
  output logic [BITS-1:0] res_data,
  output logic            res_carry,
  output logic            res_over
);

  localparam int unsigned Shift = 2 ** K;
  // Upper Shift bits, used to sign-fill arithmetic right shifts.
  localparam logic [BITS-1:0] HiMask = ~({BITS{1'b1}} >> Shift);

  // Apply this layer's shift; the last active layer leaves the final carry behind.
  always_comb begin
    res_data  = data;
    res_carry = carry;
    res_over  = over;
    if (en) begin
      case (mode)
        ModeSll, ModeSla: begin
          res_data  = data << Shift;
          res_carry = data[BITS-Shift];
          // Every bit pushed out, and every intermediate MSB, must match the original sign.
          if (mode == ModeSla) begin
            res_over = over | (data[BITS-1 -: Shift] != {Shift{sign}}) |
                       (res_data[BITS-1] != sign);
          end
        end
        ModeSrl: begin
          res_data  = data >> Shift;
          res_carry = data[Shift-1];
        end
        ModeSra: begin
          res_data  = (data >> Shift) | (sign ? HiMask : '0);
          res_carry = data[Shift-1];
        end
        ModeRol: begin
          res_data  = (data << Shift) | (data >> (BITS - Shift));
          res_carry = res_data[0];
        end
        ModeRor: begin
          res_data  = (data >> Shift) | (data << (BITS - Shift));
          res_carry = res_data[BITS-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter with valid/ready on both sides. log2(BITS) layers are spread over
// PIPE_STAGES register ranks; the whole pipe advances together whenever the output can move.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int unsigned BITS        = 8,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  A,
  input  logic [BITS-1:0]  B,
  input  logic [2:0]       mode,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  M,
  output logic             carry,
  output logic             over,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned Layers  = $clog2(BITS);
  localparam int unsigned PerRank = Layers / PIPE_STAGES;
  localparam logic [BITS-1:0] RangeLimit = BITS'(BITS);

  typedef struct packed {
    logic              valid;
    logic [BITS-1:0]   data;
    logic [Layers-1:0] amt;
    logic [2:0]        mode;
    logic              sign;
    logic              carry;
    logic              over;
    logic [TAG_W-1:0]  tag;
  } stage_t;

  stage_t entry;
  stage_t out_stage;
  stage_t lin    [Layers];
  stage_t lout   [Layers];
  stage_t rank_q [PIPE_STAGES];
  logic   adv;
  logic   fill;

  assign out_stage = rank_q[PIPE_STAGES-1];
  assign adv       = !out_stage.valid | out_ready;
  assign in_ready  = adv;

  // Range check and illegal-mode handling; such ops enter with amt=0 so no layer touches them.
  always_comb begin
    entry       = '0;
    entry.valid = in_valid;
    entry.mode  = mode;
    entry.sign  = A[BITS-1];
    entry.tag   = tag_in;
    fill        = (mode == ModeSra) & A[BITS-1];
    if (mode_illegal(mode)) begin
      entry.over = 1'b1;
    end else if (!mode_rotate(mode) && (B >= RangeLimit)) begin
      entry.data = {BITS{fill}};
      entry.over = 1'b1;
      if (B == RangeLimit) begin
        entry.carry = mode_left(mode) ? A[BITS-1] : A[0];
      end else begin
        entry.carry = fill;
      end
    end else begin
      entry.data = A;
      entry.amt  = B[Layers-1:0];
    end
  end

  // Layers go to ranks in equal contiguous groups; any remainder lands in the last rank.
  for (genvar k = 0; k < Layers; k++) begin : g_layer
    localparam int unsigned Rank =
        (k / PerRank >= PIPE_STAGES) ? PIPE_STAGES - 1 : k / PerRank;
    logic [BITS-1:0] l_data;
    logic            l_carry;
    logic            l_over;

    if (k == Rank * PerRank) begin : g_head
      if (Rank == 0) begin : g_entry
        assign lin[k] = entry;
      end else begin : g_reg
        assign lin[k] = rank_q[Rank-1];
      end
    end else begin : g_chain
      assign lin[k] = lout[k-1];
    end

    shift_layer #(
      .BITS(BITS),
      .K   (k)
    ) u_layer (
      .en       (lin[k].amt[k]),
      .data     (lin[k].data),
      .mode     (lin[k].mode),
      .sign     (lin[k].sign),
      .carry    (lin[k].carry),
      .over     (lin[k].over),
      .res_data (l_data),
      .res_carry(l_carry),
      .res_over (l_over)
    );

    assign lout[k] = '{valid: lin[k].valid, data: l_data, amt: lin[k].amt,
                       mode: lin[k].mode, sign: lin[k].sign, carry: l_carry,
                       over: l_over, tag: lin[k].tag};
  end

  for (genvar r = 0; r < PIPE_STAGES; r++) begin : g_rank
    localparam int unsigned Last =
        (r == PIPE_STAGES - 1) ? Layers - 1 : (r + 1) * PerRank - 1;
    // All ranks move on adv together so bubbles and ops stay in lockstep.
    always_ff @(posedge clk) begin
      if (rst) begin
        rank_q[r] <= '0;
      end else if (adv) begin
        rank_q[r] <= lout[Last];
      end
    end
  end

  assign out_valid = out_stage.valid;
  assign M         = out_stage.data;
  assign carry     = out_stage.carry;
  assign over      = out_stage.over;
  assign tag_out   = out_stage.tag;

  // Control fields are spent by the time an op reaches the output.
  logic unused_fields;
  assign unused_fields = ^{out_stage.amt, out_stage.mode, out_stage.sign};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench: three shift units (PIPE_STAGES 1, 2, 3) run side by side, each with its own
// driver, expectation queue and output monitor.
module tb_shift_unit_pipe;
  import shift_pkg::*;

  localparam int unsigned BITS  = 8;
  localparam int unsigned TAG_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] m;
    logic       c;
    logic       o;
    logic [3:0] tag;
    int         acc;
    bit         lat;
  } exp_t;

  // Behavioural reference: shifts done on widened words, SLA overflow as a signed range test.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] md, input logic [3:0] tg);
    exp_t        e;
    logic [15:0] w;
    logic [23:0] x;
    logic        fill;
    int          r;
    int          sv;
    e.m = '0; e.c = 1'b0; e.o = 1'b0; e.tag = tg; e.acc = 0; e.lat = 1'b0;
    fill = (md == 3'd2) & a[7];
    case (md)
      3'd0, 3'd3: begin
        if (b >= 8) begin
          e.o = 1'b1;
          e.c = (b == 8) ? a[7] : 1'b0;
        end else begin
          w   = {8'h00, a} << b;
          e.m = w[7:0];
          e.c = w[8];
          if (md == 3'd3) begin
            sv  = $signed(a) * (1 << b);
            e.o = (sv > 127) || (sv < -128);
          end
        end
      end
      3'd1, 3'd2: begin
        if (b >= 8) begin
          e.o = 1'b1;
          e.m = {8{fill}};
          e.c = (b == 8) ? a[0] : fill;
        end else begin
          x   = {{8{fill}}, a, 8'h00} >> b;
          x   = x | ({{8{fill}}, 16'h0000} & ~({24{1'b1}} >> b));
          e.m = x[15:8];
          e.c = x[7];
        end
      end
      3'd4: begin
        r   = b % 8;
        w   = {a, a} << r;
        e.m = w[15:8];
        e.c = (r == 0) ? 1'b0 : e.m[0];
      end
      3'd5: begin
        r   = b % 8;
        w   = {a, a} >> r;
        e.m = w[7:0];
        e.c = (r == 0) ? 1'b0 : e.m[7];
      end
      default: e.o = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL p%0d %s: got %0h want %0h", inst, name, got, want);
    end
  endtask

  task automatic fail_now(input string name, input int inst);
    n_checks++;
    n_errors++;
    $display("FAIL p%0d %s: got timeout/none want event", inst, name);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_p
    localparam int unsigned P = gi + 1;

    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] mode = '0;
    logic [3:0] tag_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] m;
    logic       carry;
    logic       over;
    logic [3:0] tag_out;

    exp_t q[$];
    int   cyc = 0;
    int   ready_mode = 0;
    bit   acc = 1'b0;
    bit   fin = 1'b0;

    shift_unit_pipe #(
      .BITS       (BITS),
      .PIPE_STAGES(P),
      .TAG_W      (TAG_W)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (a),
      .B        (b),
      .mode     (mode),
      .tag_in   (tag_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .M        (m),
      .carry    (carry),
      .over     (over),
      .tag_out  (tag_out)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // One cycle of stimulus; the expectation is queued only if the op is actually taken.
    task automatic drive(input bit v, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [2:0] md, input logic [3:0] tg, input bit lat);
      exp_t e;
      @(negedge clk);
      in_valid = v; a = ia; b = ib; mode = md; tag_in = tg;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      #1;
      acc = v && (in_ready === 1'b1);
      if (acc) begin
        e = model(ia, ib, md, tg);
        e.acc = cyc;
        e.lat = lat;
        q.push_back(e);
      end
    endtask

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] md,
                         input logic [3:0] tg, input bit lat);
      int tries = 0;
      do begin
        drive(1'b1, ia, ib, md, tg, lat);
        tries++;
      end while (!acc && tries < 50);
      if (!acc) fail_now("accept", P);
    endtask

    task automatic drain();
      int tries = 0;
      ready_mode = 0;
      while (q.size() != 0 && tries < 100) begin
        drive(1'b0, 8'h00, 8'h00, 3'd0, 4'h0, 1'b0);
        tries++;
      end
      if (q.size() != 0) fail_now("drain", P);
    endtask

    // Monitor: whatever is presented must equal the oldest outstanding expectation.
    initial forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (!rst && out_valid === 1'b1) begin
        if (q.size() == 0) begin
          fail_now("unexpected_output", P);
        end else begin
          e = q[0];
          check("M", P, 32'(m), 32'(e.m));
          check("carry", P, 32'(carry), 32'(e.c));
          check("over", P, 32'(over), 32'(e.o));
          check("tag_out", P, 32'(tag_out), 32'(e.tag));
          if (e.lat) begin
            check("latency", P, cyc - e.acc, P);
            q[0].lat = 1'b0;
          end
          if (out_ready) void'(q.pop_front());
        end
      end
    end

    initial begin
      logic [7:0] rb;
      repeat (3) @(negedge clk);
      check("rst_out_valid", P, 32'(out_valid), 0);
      check("rst_M", P, 32'(m), 0);
      check("rst_carry", P, 32'(carry), 0);
      check("rst_over", P, 32'(over), 0);
      check("rst_tag_out", P, 32'(tag_out), 0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("in_ready_after_rst", P, 32'(in_ready), 1);

      // Directed cases, first one also timed.
      ready_mode = 0;
      issue(8'h90, 8'd3, 3'd2, 4'h1, 1'b1);
      issue(8'h81, 8'd8, 3'd0, 4'h2, 1'b0);
      issue(8'h81, 8'h80, 3'd1, 4'h3, 1'b0);
      issue(8'h96, 8'd11, 3'd4, 4'h4, 1'b0);
      issue(8'h01, 8'd1, 3'd5, 4'h5, 1'b0);
      issue(8'h40, 8'd1, 3'd3, 4'h6, 1'b0);
      issue(8'hF0, 8'd2, 3'd3, 4'h7, 1'b0);
      issue(8'hAB, 8'd3, 3'd7, 4'h8, 1'b0);
      issue(8'h5C, 8'd9, 3'd2, 4'h9, 1'b0);
      drain();

      // Stream under a 1,0,0,1 ready pattern.
      ready_mode = 1;
      for (int i = 0; i < 8; i++) begin
        issue(8'($urandom), 8'($urandom_range(0, 9)), 3'($urandom_range(0, 5)), 4'(i), 1'b0);
      end
      drain();

      // Random traffic with random backpressure and idle gaps.
      ready_mode = 2;
      for (int i = 0; i < 150; i++) begin
        rb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
        if ($urandom_range(0, 4) == 0) drive(1'b0, 8'h00, 8'h00, 3'd0, 4'h0, 1'b0);
        issue(8'($urandom), rb, 3'($urandom_range(0, 7)), 4'($urandom), 1'b0);
      end
      drain();

      // Reset with ops in flight: they must vanish.
      ready_mode = 3;
      drive(1'b1, 8'h12, 8'd1, 3'd0, 4'hA, 1'b0);
      drive(1'b1, 8'h34, 8'd2, 3'd1, 4'hB, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        #1;
        check("rst_drop_out_valid", P, 32'(out_valid), 0);
      end
      check("in_ready_after_drop", P, 32'(in_ready), 1);

      ready_mode = 0;
      issue(8'hFF, 8'd2, 3'd7, 4'hC, 1'b0);
      issue(8'h33, 8'd0, 3'd4, 4'hD, 1'b0);
      drain();
      fin = 1'b1;
    end
  end

  initial begin
    fork
      wait (g_p[0].fin && g_p[1].fin && g_p[2].fin);
      #500000;
    join_any
    if (!(g_p[0].fin && g_p[1].fin && g_p[2].fin)) fail_now("global_timeout", 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
